imem_load_ctrl: RTL and testbench
=================================

IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 Parameter DEPTH, default 256: instruction-memory size in 32-bit words, power of two.
REQ-002 Parameter AW, default 8: word-address width, log2(DEPTH).
REQ-003 Parameter MAX_CYCLES, default 1024: run-time watchdog limit in clock cycles.
REQ-004 Port CLK  in  1: single clock; all state on rising edge.
REQ-005 Port RST  in  1: reset, asynchronous, active-low.
REQ-006 Port start  in  1: pulse; begins a program load.
REQ-007 Port len  in  AW+1: number of words to load, legal range 1..DEPTH.
REQ-008 Port in_valid  in  1 / in_data  in  32 / in_ready  out  1: program word stream, valid/ready handshake.
REQ-009 Port W_Ins  out  32 / W_Addr  out  AW / WE  out  1: instruction-memory write port to the CPU fetch stage.
REQ-010 Port PC  in  32: CPU current byte PC.
REQ-011 Port cpu_rst_n  out  1: CPU reset, active-low; low whenever not in RUN.
REQ-012 Port busy  out  1 / halt  out  1 / err  out  1 / cyc_cnt  out  32: status.

Function
REQ-013 FSM states IDLE, LOAD, RUN, HALT; busy=1 in LOAD and RUN only.
REQ-014 IDLE: in_ready=0, cpu_rst_n=0; start with 1<=len<=DEPTH -> LOAD, latch len, word counter=0, err cleared.
REQ-015 start with len=0 or len>DEPTH in IDLE or HALT -> err=1, state unchanged.
REQ-016 LOAD: in_ready=1 until len words accepted; transfer = in_valid&&in_ready same cycle.
REQ-017 Each transfer -> next cycle WE=1 for exactly one cycle, W_Ins=in_data, W_Addr=word counter; counter increments by 1.
REQ-018 WE=0 in every cycle not directly following a transfer; W_Ins/W_Addr hold last value.
REQ-019 in_ready drops the cycle after the len-th transfer; state -> RUN the cycle after the last WE pulse.
REQ-020 RUN: cpu_rst_n=1, cyc_cnt=0 on entry, +1 per cycle, saturating at 2^32-1.
REQ-021 RUN -> HALT when PC == 4*len (fall-through past last loaded word); err unchanged.
REQ-022 RUN -> HALT with err=1 when cyc_cnt reaches MAX_CYCLES; PC match in the same cycle takes priority (err stays 0).
REQ-023 HALT: cpu_rst_n=0, halt=1, cyc_cnt frozen; valid start -> LOAD (halt cleared, reload from word 0).
REQ-024 start while in LOAD or RUN ignored; in_valid outside LOAD ignored (in_ready=0).

Reset
REQ-025 RST low asynchronously forces IDLE; cpu_rst_n=0, in_ready=0, WE=0, W_Ins=0, W_Addr=0, busy=0, halt=0, err=0, cyc_cnt=0.
REQ-026 Reset asserted mid-LOAD or mid-RUN aborts immediately; no WE pulse issued after RST falls; partial program not resumed.
REQ-027 After RST release, first state change requires a new start.

Configuration
REQ-028 Macro IMEM_CHECKSUM_EN defined: extra input chk_expect 32; controller sums accepted words mod 2^32 (cleared on LOAD entry).
REQ-029 With IMEM_CHECKSUM_EN: end of LOAD compares sum to chk_expect; mismatch -> HALT with err=1, RUN skipped, cpu_rst_n stays 0; match -> RUN.
REQ-030 Without IMEM_CHECKSUM_EN: chk_expect port absent, no sum logic, LOAD always proceeds to RUN.

Verification
REQ-031 len=3, words 0x20080005,0x20090007,0x01095020, in_valid always 1 -> three WE pulses addr 0,1,2, RUN, halt when PC=12, err=0.
REQ-032 len=4, in_valid toggling 1,0,0,1,... -> WE only after transfers, addresses 0..3 contiguous, no duplicate or lost write.
REQ-033 Program looping forever (PC never 4*len), MAX_CYCLES=1024 -> HALT at cyc_cnt=1024, err=1, cpu_rst_n=0.
REQ-034 RST pulled low after 2 of 5 words -> immediate IDLE, WE=0, all outputs at reset values; new start reloads from addr 0.
REQ-035 start with len=0 and with len=DEPTH+1 -> err=1, stays IDLE, no in_ready.
REQ-036 IMEM_CHECKSUM_EN, words 1,2,3, chk_expect=7 -> HALT, err=1, no RUN; chk_expect=6 -> RUN.

Source files
------------

// File: rtl/imem_load_ctrl.sv
// Instruction-memory loader: streams len words into the CPU's IMEM, then releases the CPU and watches for halt/timeout.
// Optional build macro IMEM_CHECKSUM_EN adds chk_expect and gates RUN on a mod-2^32 word sum.
module imem_load_ctrl #(
  parameter int DEPTH      = 256,
  parameter int AW         = 8,
  parameter int MAX_CYCLES = 1024
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic [AW:0]   len,
  input  logic          in_valid,
  input  logic [31:0]   in_data,
  output logic          in_ready,
  output logic [31:0]   W_Ins,
  output logic [AW-1:0] W_Addr,
  output logic          WE,
  input  logic [31:0]   PC,
  output logic          cpu_rst_n,
  output logic          busy,
  output logic          halt,
  output logic          err,
  output logic [31:0]   cyc_cnt
`ifdef IMEM_CHECKSUM_EN
  ,
  input  logic [31:0]   chk_expect
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   wcnt_q, wcnt_d;
  logic          we_q, we_d;
  logic [31:0]   w_ins_q, w_ins_d;
  logic [AW-1:0] w_addr_q, w_addr_d;
  logic          in_ready_q, in_ready_d;
  logic          cpu_rst_n_q, cpu_rst_n_d;
  logic          busy_q, busy_d;
  logic          halt_q, halt_d;
  logic          err_q, err_d;
  logic [31:0]   cyc_cnt_q, cyc_cnt_d;
  logic [31:0]   sum_q, sum_d;

  logic          xfer_s;
  logic          len_ok_s;
  logic          pc_hit_s;
  logic          chk_ok_s;
  logic [31:0]   cnt_inc_s;

  assign xfer_s    = in_valid && in_ready_q;
  assign len_ok_s  = (len != '0) && ({{(31-AW){1'b0}}, len} <= 32'(DEPTH));
  assign pc_hit_s  = (PC == {{(29-AW){1'b0}}, len_q, 2'b00});
  assign cnt_inc_s = (cyc_cnt_q == 32'hFFFF_FFFF) ? cyc_cnt_q : (cyc_cnt_q + 32'd1);

`ifdef IMEM_CHECKSUM_EN
  assign chk_ok_s = (sum_q == chk_expect);
`else
  assign chk_ok_s = 1'b1;
`endif

  // Next-state and next-output logic; every status output is computed from the next state so it is registered.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wcnt_d    = wcnt_q;
    we_d      = 1'b0;
    w_ins_d   = w_ins_q;
    w_addr_d  = w_addr_q;
    err_d     = err_q;
    cyc_cnt_d = cyc_cnt_q;
    sum_d     = sum_q;

    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          if (len_ok_s) begin
            state_d = S_LOAD;
            len_d   = len;
            wcnt_d  = '0;
            err_d   = 1'b0;
            sum_d   = 32'd0;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_LOAD: begin
        if (xfer_s) begin
          we_d     = 1'b1;
          w_ins_d  = in_data;
          w_addr_d = wcnt_q[AW-1:0];
          wcnt_d   = wcnt_q + (AW+1)'(1);
          sum_d    = sum_q + in_data;
        end else if (we_q && (wcnt_q == len_q)) begin
          // Last write is on the bus this cycle; the sum is now complete.
          if (chk_ok_s) begin
            state_d   = S_RUN;
            cyc_cnt_d = 32'd0;
          end else begin
            state_d = S_HALT;
            err_d   = 1'b1;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_RUN: begin
        cyc_cnt_d = cnt_inc_s;
        if (pc_hit_s) begin
          state_d = S_HALT;
        end else if (cnt_inc_s == 32'(MAX_CYCLES)) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d  = (state_d == S_LOAD) && (wcnt_d != len_d);
    cpu_rst_n_d = (state_d == S_RUN);
    busy_d      = (state_d == S_LOAD) || (state_d == S_RUN);
    halt_d      = (state_d == S_HALT);
  end

  // State and output registers; reset aborts any load or run in progress.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      wcnt_q      <= '0;
      we_q        <= 1'b0;
      w_ins_q     <= 32'd0;
      w_addr_q    <= '0;
      in_ready_q  <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      halt_q      <= 1'b0;
      err_q       <= 1'b0;
      cyc_cnt_q   <= 32'd0;
      sum_q       <= 32'd0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wcnt_q      <= wcnt_d;
      we_q        <= we_d;
      w_ins_q     <= w_ins_d;
      w_addr_q    <= w_addr_d;
      in_ready_q  <= in_ready_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      busy_q      <= busy_d;
      halt_q      <= halt_d;
      err_q       <= err_d;
      cyc_cnt_q   <= cyc_cnt_d;
      sum_q       <= sum_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign W_Ins     = w_ins_q;
  assign W_Addr    = w_addr_q;
  assign WE        = we_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign busy      = busy_q;
  assign halt      = halt_q;
  assign err       = err_q;
  assign cyc_cnt   = cyc_cnt_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Randomized self-checking bench for imem_load_ctrl against a transaction-level model of load/run/halt.
module tb_imem_load_ctrl;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int MAXC  = 1024;

  logic          CLK = 1'b0;
  logic          RST;
  logic          start;
  logic [AW:0]   len;
  logic          in_valid;
  logic [31:0]   in_data;
  logic          in_ready;
  logic [31:0]   W_Ins;
  logic [AW-1:0] W_Addr;
  logic          WE;
  logic [31:0]   PC;
  logic          cpu_rst_n;
  logic          busy;
  logic          halt;
  logic          err;
  logic [31:0]   cyc_cnt;
`ifdef IMEM_CHECKSUM_EN
  logic [31:0]   chk_expect;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0]   prog [0:DEPTH-1];
  logic [AW-1:0] last_addr = '0;
  logic [31:0]   last_data = 32'd0;

  imem_load_ctrl #(.DEPTH(DEPTH), .AW(AW), .MAX_CYCLES(MAXC)) dut (
    .CLK(CLK), .RST(RST), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .W_Ins(W_Ins), .W_Addr(W_Addr), .WE(WE), .PC(PC),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .halt(halt), .err(err), .cyc_cnt(cyc_cnt)
`ifdef IMEM_CHECKSUM_EN
    , .chk_expect(chk_expect)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, WE, 1'b0);
    check({tag, "_rdy"}, in_ready, 1'b0);
    check({tag, "_cpu"}, cpu_rst_n, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_halt"}, halt, 1'b0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_cyc"}, cyc_cnt, 32'd0);
    check({tag, "_ins"}, W_Ins, 32'd0);
    check({tag, "_addr"}, W_Addr, '0);
  endtask

  // Loads prog[0..n-1]; vpct<0 selects the valid pattern 1,0,0,1,0,0,...
  task automatic do_load(input int n, input int vpct, input bit bad_chk, output bit ran);
    int acc = 0;
    int iter = 0;
    bit pend = 1'b0;
    logic [AW-1:0] paddr = '0;
    logic [31:0] pdata = 32'd0;
    logic [31:0] sum = 32'd0;
    for (int i = 0; i < n; i++) sum += prog[i];
`ifdef IMEM_CHECKSUM_EN
    chk_expect = bad_chk ? (sum + 32'd1) : sum;
`endif
    @(negedge CLK);
    start = 1'b1;
    len   = (AW+1)'(n);
    @(negedge CLK);
    start = 1'b0;
    check("load_busy", busy, 1'b1);
    check("load_err_clr", err, 1'b0);
    check("load_halt_clr", halt, 1'b0);
    while (1) begin
      check("load_we", WE, pend);
      if (pend) begin
        check("load_addr", W_Addr, paddr);
        check("load_ins", W_Ins, pdata);
        last_addr = paddr;
        last_data = pdata;
      end else begin
        check("hold_addr", W_Addr, last_addr);
        check("hold_ins", W_Ins, last_data);
      end
      check("load_rdy", in_ready, (acc < n));
      check("load_cpu", cpu_rst_n, 1'b0);
      if (acc == n && pend) break;
      if (iter > 20000) begin
        n_tests++;
        n_fail++;
        $display("FAIL load_timeout: accepted %0d words, required %0d", acc, n);
        break;
      end
      in_valid = (vpct < 0) ? (iter % 3 == 0) : ($urandom_range(99) < vpct);
      in_data  = (acc < n) ? prog[acc] : $urandom;
      start    = ($urandom_range(7) == 0);
      len      = (AW+1)'($urandom);
      pend     = in_valid && (acc < n);
      if (pend) begin
        paddr = acc[AW-1:0];
        pdata = prog[acc];
        acc++;
      end
      iter++;
      @(negedge CLK);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    @(negedge CLK);
    check("post_we", WE, 1'b0);
    check("post_rdy", in_ready, 1'b0);
    ran = 1'b1;
`ifdef IMEM_CHECKSUM_EN
    if (bad_chk) begin
      ran = 1'b0;
      check("chk_halt", halt, 1'b1);
      check("chk_err", err, 1'b1);
      check("chk_cpu", cpu_rst_n, 1'b0);
      check("chk_busy", busy, 1'b0);
    end
`endif
    if (ran) begin
      check("run_cpu", cpu_rst_n, 1'b1);
      check("run_busy", busy, 1'b1);
      check("run_cyc0", cyc_cnt, 32'd0);
    end
  endtask

  // CPU reaches PC=4n at RUN cycle k (k<0: never); watchdog halts after MAXC cycles.
  task automatic do_run(input int n, input int k);
    int j = 0;
    bit hit;
    logic exp_err;
    logic [31:0] tgt = 32'(n) * 32'd4;
    while (1) begin
      check("run_cnt", cyc_cnt, 32'(j));
      check("run_cpu_hi", cpu_rst_n, 1'b1);
      hit = (j == k);
      PC  = hit ? tgt : (tgt ^ (32'd4 << $urandom_range(20)));
      j++;
      @(negedge CLK);
      if (hit) begin
        exp_err = 1'b0;
        break;
      end
      if (j == MAXC) begin
        exp_err = 1'b1;
        break;
      end
    end
    check("halt_flag", halt, 1'b1);
    check("halt_busy", busy, 1'b0);
    check("halt_cpu", cpu_rst_n, 1'b0);
    check("halt_err", err, exp_err);
    check("halt_cyc", cyc_cnt, 32'(j));
    PC = $urandom;
    @(negedge CLK);
    @(negedge CLK);
    check("halt_frozen", cyc_cnt, 32'(j));
    check("halt_stay", halt, 1'b1);
  endtask

  task automatic bad_start(input logic [AW:0] l, input logic exp_halt);
    @(negedge CLK);
    start = 1'b1;
    len   = l;
    @(negedge CLK);
    start = 1'b0;
    check("bad_err", err, 1'b1);
    check("bad_rdy", in_ready, 1'b0);
    check("bad_busy", busy, 1'b0);
    check("bad_halt", halt, exp_halt);
    @(negedge CLK);
    check("bad_rdy2", in_ready, 1'b0);
  endtask

  initial begin
    bit ran;
    int n;
    RST = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_data = 32'd0; PC = 32'd0;
`ifdef IMEM_CHECKSUM_EN
    chk_expect = 32'd0;
`endif
    #23;
    check_reset_outputs("rst");
    @(negedge CLK);
    RST = 1'b1;

    bad_start('0, 1'b0);
    bad_start((AW+1)'(DEPTH + 1), 1'b0);

    prog[0] = 32'h2008_0005; prog[1] = 32'h2009_0007; prog[2] = 32'h0109_5020;
    do_load(3, 100, 1'b0, ran);
    if (ran) do_run(3, 4);

    bad_start('0, 1'b1);

    for (int i = 0; i < DEPTH; i++) prog[i] = $urandom;
    do_load(4, -1, 1'b0, ran);
    if (ran) do_run(4, 0);

    do_load(2, 100, 1'b0, ran);
    if (ran) do_run(2, -1);

    do_load(1, 100, 1'b0, ran);
    if (ran) do_run(1, MAXC - 1);

    do_load(DEPTH, 70, 1'b0, ran);
    if (ran) do_run(DEPTH, 10);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < DEPTH; i++) prog[i] = $urandom;
      n = 1 + $urandom_range(20);
      do_load(n, 30 + $urandom_range(70), 1'b0, ran);
      if (ran) do_run(n, $urandom_range(50));
    end

    // Reset while the second write is on the bus.
    @(negedge CLK);
    start = 1'b1; len = (AW+1)'(5);
    @(negedge CLK);
    start = 1'b0; in_valid = 1'b1; in_data = prog[0];
    @(negedge CLK);
    in_data = prog[1];
    @(negedge CLK);
    check("pre_rst_we", WE, 1'b1);
    RST = 1'b0;
    #1;
    check_reset_outputs("midload");
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check("rst_hold_we", WE, 1'b0);
    end
    RST = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check("idle_rdy", in_ready, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("idle_we", WE, 1'b0);
    end
    in_valid = 1'b0;
    last_addr = '0;
    last_data = 32'd0;
    do_load(5, 100, 1'b0, ran);
    if (ran) do_run(5, 3);

`ifdef IMEM_CHECKSUM_EN
    prog[0] = 32'd1; prog[1] = 32'd2; prog[2] = 32'd3;
    do_load(3, 100, 1'b1, ran);
    do_load(3, 100, 1'b0, ran);
    if (ran) do_run(3, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
